// File: rtl/grid_dump_if.sv
// Handshake bundle between the grid read-out engine, the cell RAM read port
// and the serial TX byte sink.
interface grid_dump_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  // master: the dump engine; slave: controller, cell RAM and TX sink
  modport master (
    input  start, mem_rd_data, tx_ready,
    output busy, done, mem_rd_en, mem_addr, tx_data, tx_valid
  );

  modport slave (
    output start, mem_rd_data, tx_ready,
    input  busy, done, mem_rd_en, mem_addr, tx_data, tx_valid
  );
endinterface

// File: rtl/grid_dump.sv
// Game of Life grid read-out: scans the cell RAM row-major, packs 8 cells per
// byte MSB first and streams a header byte plus the packed grid to the TX sink.
module grid_dump #(
  parameter int          ROWS   = 16,
  parameter int          COLS   = 16,
  parameter int          ADDR_W = 8,
  parameter logic [7:0]  HDR    = 8'hA5
) (
  input  logic        c1,
  input  logic        rst,
  grid_dump_if.master bus
);

  localparam int                CELLS     = ROWS * COLS;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_READ,
    S_SEND,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [6:0]        shift_q, shift_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_fire;

  assign tx_fire = tx_valid_q && bus.tx_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    rd_en_d    = rd_en_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d    = S_HEADER;
          addr_d     = '0;
          busy_d     = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = HDR;
        end
      end

      S_HEADER: begin
        if (tx_fire) begin
          state_d    = S_READ;
          tx_valid_d = 1'b0;
          rd_en_d    = 1'b1;
          cnt_d      = 4'd0;
        end
      end

      // cnt 0..7 issue reads at a..a+7; data trails by one, so cnt 1..8 capture
      S_READ: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q != 4'd0) begin
          shift_d = {shift_q[5:0], bus.mem_rd_data};
        end
        if (cnt_q < 4'd7) begin
          addr_d = addr_q + ADDR_ONE;
        end
        if (cnt_q == 4'd7) begin
          rd_en_d = 1'b0;
        end
        if (cnt_q == 4'd8) begin
          state_d    = S_SEND;
          tx_data_d  = {shift_q, bus.mem_rd_data};
          tx_valid_d = 1'b1;
        end
      end

      // addr_q still points at the last cell of this byte, so the end test
      // never lets the counter step past the final cell
      S_SEND: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          if (addr_q == LAST_ADDR) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_READ;
            addr_d  = addr_q + ADDR_ONE;
            rd_en_d = 1'b1;
            cnt_d   = 4'd0;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge c1) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= '0;
      addr_q     <= '0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.mem_rd_en = rd_en_q;
  assign bus.mem_addr  = addr_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_data   = tx_data_q;

endmodule
